irq_pending_ctrl: RTL and testbench
===================================

# irq_pending_ctrl

Interrupt-request front end for the 8-input priority encoder path. Samples eight request lines, latches them into a pending register, and applies a per-line mask. The highest-index pending, unmasked line is presented to the consumer as a 3-bit ID with a valid/ack handshake. Acknowledging the ID clears the serviced pending bit.

## Interface
- MASK_RST, 8'hFF, mask register value after reset (1 = line enabled)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  8  raw request lines, bit 7 highest priority
- mask_we  in  1  mask write strobe
- mask_wdata  in  8  new mask value
- irq_ack  in  1  consumer accepts presented ID
- ovf_clr  in  1  clears overrun flag
- irq_valid  out  1  irq_id is valid
- irq_id  out  3  index of granted line
- pending  out  8  pending register
- mask  out  8  mask register
- ovf  out  1  sticky overrun flag

## Operation
- Sampling: req_q <= req and req_qq <= req_q on every edge.
- event is req_q & ~req_qq with IRQ_EDGE_EN defined, and req_q otherwise.
- Pending update: pending <= (pending & ~clr) | event.
  - clr is a one-hot of irq_id, gated by an accepted ack.
  - Set wins over clear on the same bit in the same cycle.
- Masking:
  - Masked lines still latch into pending.
  - eligible = pending & mask.
  - Selection is highest set index of eligible (7 beats 0).
- Mask: mask_we loads mask_wdata at the edge; the new value is used from the next cycle.
- FSM IDLE:
  - If eligible != 0: register irq_id = highest eligible index, irq_valid <= 1, go PRESENT.
  - irq_ack is ignored in IDLE.
- FSM PRESENT:
  - irq_id and irq_valid are held stable.
  - No preemption by a higher-priority arrival.
  - No retraction on a mask change.
  - On irq_ack: clear pending[irq_id], irq_valid <= 0, go IDLE.
- Overrun: ovf sets when an event hits a bit that is already pending and not being cleared that cycle.
  - ovf_clr clears ovf.
  - A simultaneous set wins over ovf_clr.

## Timing
- Reset values:
  - req_q, req_qq, pending, ovf, irq_valid: 0
  - irq_id: 3'd0
  - mask: MASK_RST
  - state: IDLE
- Reset is asynchronous assert and synchronous release. A reset mid-handshake drops irq_valid immediately.
- Latency: req high before edge E gives req_q at E, pending at E+1, and irq_valid/irq_id at E+2.
- Ack at edge A: irq_valid is low after A, and pending is cleared at A.
- The earliest next grant is after A+1 (one bubble cycle).
- Back-to-back throughput: one grant per 2 cycles.
- With edge mode, a req already high at reset release counts as a rising edge: req_qq is 0, so an event is generated.

## Configuration
- Macro: IRQ_EDGE_EN.
- Defined (edge mode):
  - Only 0->1 transitions of req create events.
  - A held-high req is serviced once.
  - ovf is active.
- Undefined (level mode):
  - req_q sets pending every cycle, so a still-asserted line re-pends immediately after ack.
  - ovf is tied 0.
  - ovf_clr is ignored.

## Test plan
- Reset with req=8'h00 → irq_valid=0, irq_id=0, pending=0, mask=8'hFF, ovf=0. Pulse req=8'h01 for 1 cycle → irq_valid high 2 edges later with irq_id=0. Ack → pending=0, irq_valid=0.
- req=8'h12 in one cycle → grant irq_id=4 first; after ack, irq_id=1 two cycles later. pending goes 8'h12 → 8'h02 → 8'h00 over the two acks.
- mask=8'h7F, req=8'h81 → irq_id=0 granted and pending[7]=1 held. Write mask=8'hFF after acking 0 → irq_id=7 presented.
- While presenting irq_id=2, raise req bit 6 → irq_id stays 2 until ack, then 6 follows.
- Edge mode: two separate pulses on bit 3 with no ack between → ovf=1. ovf_clr → ovf=0. A pulse plus ovf_clr in the same cycle → ovf remains 1.
- Assert rst_n=0 during PRESENT with irq_id=5 → irq_valid=0 and pending=0 immediately, with no grant after release while req=0.

Source files
------------

// File: rtl/irq_pending_ctrl.sv
// Eight-line interrupt front end: pending latch, per-line mask, highest-index grant with valid/ack.
// Define IRQ_EDGE_EN for rising-edge capture with overrun detection; otherwise requests are level-sensitive.
module irq_pending_ctrl #(
   parameter logic [7:0] MASK_RST = 8'hFF
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_req,
   input  logic       i_mask_we,
   input  logic [7:0] i_mask_wdata,
   input  logic       i_irq_ack,
   input  logic       i_ovf_clr,
   output logic       o_irq_valid,
   output logic [2:0] o_irq_id,
   output logic [7:0] o_pending,
   output logic [7:0] o_mask,
   output logic       o_ovf
);

   typedef enum logic {
      ST_IDLE,
      ST_PRESENT
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_req_q;
   logic [7:0] r_req_qq;
   logic [7:0] r_pending;
   logic [7:0] r_mask;
   logic [2:0] r_irq_id;
   logic       r_irq_valid;
   logic [2:0] w_id_nxt;
   logic       w_valid_nxt;
   logic [7:0] w_event;
   logic [7:0] w_clr;
   logic [7:0] w_eligible;
   logic [2:0] w_hi_idx;
   logic       w_ack_acc;

`ifdef IRQ_EDGE_EN
   assign w_event = r_req_q & ~r_req_qq;
`else
   assign w_event = r_req_q;
`endif

   assign w_ack_acc  = (r_state == ST_PRESENT) && i_irq_ack;
   assign w_clr      = w_ack_acc ? (8'b1 << r_irq_id) : 8'h00;
   assign w_eligible = r_pending & r_mask;

   // Ascending scan so the highest set index is the last one written.
   always_comb begin
      w_hi_idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (w_eligible[i]) begin
            w_hi_idx = 3'(i);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_req_q   <= 8'h00;
         r_req_qq  <= 8'h00;
         r_pending <= 8'h00;
         r_mask    <= MASK_RST;
      end else begin
         r_req_q   <= i_req;
         r_req_qq  <= r_req_q;
         r_pending <= (r_pending & ~w_clr) | w_event;
         if (i_mask_we) begin
            r_mask <= i_mask_wdata;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_irq_id    <= 3'd0;
         r_irq_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_irq_id    <= w_id_nxt;
         r_irq_valid <= w_valid_nxt;
      end
   end

   // Once presented, the ID is frozen until acked: no preemption, no retraction on mask change.
   always_comb begin
      w_state_nxt = r_state;
      w_id_nxt    = r_irq_id;
      w_valid_nxt = r_irq_valid;
      case (r_state)
         ST_IDLE: begin
            if (w_eligible != 8'h00) begin
               w_state_nxt = ST_PRESENT;
               w_id_nxt    = w_hi_idx;
               w_valid_nxt = 1'b1;
            end
         end
         ST_PRESENT: begin
            if (i_irq_ack) begin
               w_state_nxt = ST_IDLE;
               w_valid_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
         end
      endcase
   end

`ifdef IRQ_EDGE_EN
   logic r_ovf;
   logic w_ovf_hit;

   assign w_ovf_hit = |(w_event & r_pending & ~w_clr);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_ovf_hit) begin
         r_ovf <= 1'b1;
      end else if (i_ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

   assign o_ovf = r_ovf;
`else
   logic w_unused_level;

   assign w_unused_level = ^{i_ovf_clr, r_req_qq};
   assign o_ovf          = 1'b0;
`endif

   assign o_irq_valid = r_irq_valid;
   assign o_irq_id    = r_irq_id;
   assign o_pending   = r_pending;
   assign o_mask      = r_mask;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl: expected grant IDs are queued when requests are driven
// and popped when the DUT presents them; register state is checked against hand-derived constants.
module tb_irq_pending_ctrl;

   logic       clk;
   logic       rstN;
   logic [7:0] req;
   logic       maskWe;
   logic [7:0] maskWdata;
   logic       irqAck;
   logic       ovfClr;
   logic       irqValid;
   logic [2:0] irqId;
   logic [7:0] pending;
   logic [7:0] mask;
   logic       ovf;

   int compared = 0;
   int mismatched = 0;
   logic [2:0] expectQ[$];

`ifdef IRQ_EDGE_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   irq_pending_ctrl #(.MASK_RST(8'hFF)) dut (
      .i_clk        (clk),
      .i_rst_n      (rstN),
      .i_req        (req),
      .i_mask_we    (maskWe),
      .i_mask_wdata (maskWdata),
      .i_irq_ack    (irqAck),
      .i_ovf_clr    (ovfClr),
      .o_irq_valid  (irqValid),
      .o_irq_id     (irqId),
      .o_pending    (pending),
      .o_mask       (mask),
      .o_ovf        (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic popGrant(input string tag);
      logic [2:0] expId;
      checkOutput({tag, "_valid"}, {7'd0, irqValid}, 8'h01);
      if (expectQ.size() == 0) begin
         compared++;
         mismatched++;
         $error("[TB] FAIL %s_queue: observed empty scoreboard expected an entry", tag);
      end else begin
         expId = expectQ.pop_front();
         checkOutput({tag, "_id"}, {5'd0, irqId}, {5'd0, expId});
      end
   endtask

   task automatic waitGrant(input string tag, input int budget);
      int n = 0;
      while (irqValid !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      if (irqValid !== 1'b1) begin
         compared++;
         mismatched++;
         $error("[TB] FAIL %s_timeout: observed no grant expected grant within %0d cycles", tag, budget);
      end else begin
         popGrant(tag);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] pulse);
      req = pulse;
      tick();
      req = 8'h00;
   endtask

   task automatic ackGrant(input string tag);
      irqAck = 1'b1;
      tick();
      irqAck = 1'b0;
      checkOutput({tag, "_valid_after_ack"}, {7'd0, irqValid}, 8'h00);
   endtask

   initial begin
      rstN = 1'b0;
      req = 8'h00;
      maskWe = 1'b0;
      maskWdata = 8'h00;
      irqAck = 1'b0;
      ovfClr = 1'b0;
      repeat (3) tick();
      checkOutput("rst_valid", {7'd0, irqValid}, 8'h00);
      checkOutput("rst_id", {5'd0, irqId}, 8'h00);
      checkOutput("rst_pending", pending, 8'h00);
      checkOutput("rst_mask", mask, 8'hFF);
      checkOutput("rst_ovf", {7'd0, ovf}, 8'h00);
      rstN = 1'b1;
      tick();

      // Single pulse: pending one edge after capture, grant one edge after that.
      expectQ.push_back(3'd0);
      applyStimulus(8'h01);
      checkOutput("t1_pending_e", pending, 8'h00);
      tick();
      checkOutput("t1_pending_e1", pending, 8'h01);
      checkOutput("t1_valid_e1", {7'd0, irqValid}, 8'h00);
      tick();
      popGrant("t1_grant");
      ackGrant("t1");
      checkOutput("t1_pending_ack", pending, 8'h00);

      // Two lines at once: highest index first, one bubble cycle between grants.
      expectQ.push_back(3'd4);
      expectQ.push_back(3'd1);
      applyStimulus(8'h12);
      tick();
      checkOutput("t2_pending", pending, 8'h12);
      tick();
      popGrant("t2_first");
      ackGrant("t2_first");
      checkOutput("t2_pending_mid", pending, 8'h02);
      tick();
      popGrant("t2_second");
      ackGrant("t2_second");
      checkOutput("t2_pending_end", pending, 8'h00);

      // Masked line still pends and is presented once the mask is reopened.
      maskWe = 1'b1;
      maskWdata = 8'h7F;
      tick();
      maskWe = 1'b0;
      checkOutput("t3_mask", mask, 8'h7F);
      expectQ.push_back(3'd0);
      applyStimulus(8'h81);
      tick();
      checkOutput("t3_pending", pending, 8'h81);
      tick();
      popGrant("t3_first");
      ackGrant("t3_first");
      checkOutput("t3_pending_held", pending, 8'h80);
      tick();
      tick();
      checkOutput("t3_masked_idle", {7'd0, irqValid}, 8'h00);
      maskWe = 1'b1;
      maskWdata = 8'hFF;
      expectQ.push_back(3'd7);
      tick();
      maskWe = 1'b0;
      checkOutput("t3_mask_open", mask, 8'hFF);
      waitGrant("t3_second", 4);
      ackGrant("t3_second");
      checkOutput("t3_pending_end", pending, 8'h00);

      // Higher-priority arrival during PRESENT does not preempt.
      expectQ.push_back(3'd2);
      applyStimulus(8'h04);
      waitGrant("t4_first", 4);
      expectQ.push_back(3'd6);
      applyStimulus(8'h40);
      tick();
      tick();
      checkOutput("t4_hold_valid", {7'd0, irqValid}, 8'h01);
      checkOutput("t4_hold_id", {5'd0, irqId}, 8'h02);
      checkOutput("t4_pending", pending, 8'h44);
      ackGrant("t4_first");
      waitGrant("t4_second", 4);
      ackGrant("t4_second");
      checkOutput("t4_pending_end", pending, 8'h00);

      // Overrun: second pulse on an already-pending line; set beats a same-cycle clear.
      expectQ.push_back(3'd3);
      applyStimulus(8'h08);
      tick();
      tick();
      applyStimulus(8'h08);
      tick();
      checkOutput("t5_ovf_set", {7'd0, ovf}, {7'd0, OVF_ON});
      popGrant("t5_grant");
      ovfClr = 1'b1;
      tick();
      ovfClr = 1'b0;
      checkOutput("t5_ovf_clr", {7'd0, ovf}, 8'h00);
      applyStimulus(8'h08);
      ovfClr = 1'b1;
      tick();
      ovfClr = 1'b0;
      checkOutput("t5_ovf_set_wins", {7'd0, ovf}, {7'd0, OVF_ON});
      ovfClr = 1'b1;
      tick();
      ovfClr = 1'b0;
      checkOutput("t5_ovf_final", {7'd0, ovf}, 8'h00);
      ackGrant("t5");
      checkOutput("t5_pending_end", pending, 8'h00);

      // Reset during PRESENT drops valid and pending without waiting for a clock.
      expectQ.push_back(3'd5);
      applyStimulus(8'h20);
      waitGrant("t6_grant", 4);
      #1;
      rstN = 1'b0;
      #1;
      checkOutput("t6_rst_valid", {7'd0, irqValid}, 8'h00);
      checkOutput("t6_rst_pending", pending, 8'h00);
      checkOutput("t6_rst_id", {5'd0, irqId}, 8'h00);
      tick();
      rstN = 1'b1;
      repeat (3) tick();
      checkOutput("t6_no_grant", {7'd0, irqValid}, 8'h00);
      checkOutput("t6_no_pending", pending, 8'h00);

      // A request already high at release is captured as a new event.
      rstN = 1'b0;
      req = 8'h01;
      tick();
      tick();
      rstN = 1'b1;
      expectQ.push_back(3'd0);
      tick();
      req = 8'h00;
      waitGrant("t7_release", 4);
      ackGrant("t7");
      checkOutput("t7_pending_end", pending, 8'h00);
      checkOutput("t7_queue_empty", 8'(expectQ.size()), 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
